// File: rtl/data_sram_resp_pkg.sv
// rtl/data_sram_resp_pkg.sv - shared constants and range-decode helper for the data SRAM responder
package data_sram_resp_pkg;

  localparam int          DSRAM_ADDR_WIDTH_DEFAULT = 12;
  localparam logic [31:0] DSRAM_BASE_DEFAULT       = 32'h0000_0000;
  localparam int          WORD_BYTES               = 4;
  // Byte-enable width of the data SRAM bus, matching the core's bus definitions.
  localparam int          DSRAM_BE_WIDTH           = 4;

  typedef logic [DSRAM_BE_WIDTH-1:0] be_t;

  // True when every address bit above the word index matches the base address.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int          aw);
    logic [31:0] diff;
    diff = (addr ^ base) >> (aw + 2);
    return (diff == 32'h0);
  endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// rtl/data_sram_resp_if.sv - data SRAM request/response bus between requester and responder
interface data_sram_resp_if;
  import data_sram_resp_pkg::*;

  logic        data_sram_en;
  be_t         data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        data_sram_err;

  modport master (
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, data_sram_err
  );

  modport slave (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, data_sram_err
  );

endinterface

// File: rtl/data_sram_resp_array.sv
// rtl/data_sram_resp_array.sv - reset-free word array with byte-lane writes and read-first registered read
module dsram_array
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = DSRAM_ADDR_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  en,
  input  be_t                   we,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  // Read-first port: rdata captures the old word while enabled lanes are overwritten.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[idx];
      for (int i = 0; i < DSRAM_BE_WIDTH; i++) begin
        if (we[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data SRAM responder: range decode, error pulse, output zeroing, access counters
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          ADDR_WIDTH = DSRAM_ADDR_WIDTH_DEFAULT,
  parameter logic [31:0] BASE_ADDR  = DSRAM_BASE_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  data_sram_resp_if.slave    bus,
  output logic [31:0]        rd_cnt,
  output logic [31:0]        wr_cnt
);

  logic                  in_range;
  logic                  req_ok;
  logic                  req_bad;
  logic                  arr_en;
  logic                  is_write;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           arr_rdata;
  logic                  rd_valid_q;
  logic                  err_q;
  logic [31:0]           rd_cnt_q;
  logic [31:0]           wr_cnt_q;

  assign in_range = addr_in_range(bus.data_sram_addr, BASE_ADDR, ADDR_WIDTH);
  assign req_ok   = bus.data_sram_en && in_range;
  assign req_bad  = bus.data_sram_en && !in_range;
  assign is_write = |bus.data_sram_we;
  assign idx      = bus.data_sram_addr[ADDR_WIDTH+1:2];
  // The array has no reset, so a request that coincides with reset is blocked here.
  assign arr_en   = req_ok && !reset;

  dsram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (bus.data_sram_we),
    .idx   (idx),
    .wdata (bus.data_sram_wdata),
    .rdata (arr_rdata)
  );

  // rd_valid_q selects array data or zero; it holds across idle cycles so rdata holds too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= req_bad;
      if (req_ok) begin
        rd_valid_q <= 1'b1;
      end else if (req_bad) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  // Saturating access counters, stepped only by accepted in-range requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else if (req_ok) begin
      if (is_write) begin
        if (wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
      end else begin
        if (rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
      end
    end
  end

  // Both operands are registers, so no input-to-output combinational path exists.
  assign bus.data_sram_rdata = rd_valid_q ? arr_rdata : 32'h0;
  assign bus.data_sram_err   = err_q;
  assign rd_cnt              = rd_cnt_q;
  assign wr_cnt              = wr_cnt_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - directed self-checking bench for data_sram_resp
module tb_data_sram_resp;

  logic        clk;
  logic        reset;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  int          errors;
  int          checks;

  data_sram_resp_if bus ();

  data_sram_resp #(
    .ADDR_WIDTH (12),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .rd_cnt (rd_cnt),
    .wr_cnt (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request at the falling edge, lets a rising edge take it, returns at the next falling edge.
  task automatic req(input logic en, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.data_sram_en    = en;
    bus.data_sram_we    = we;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.data_sram_en    = 1'b0;
    bus.data_sram_we    = 4'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.data_sram_en = 1'b0; bus.data_sram_we = 4'h0;
    bus.data_sram_addr = 32'h0; bus.data_sram_wdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++; if (bus.data_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", bus.data_sram_rdata, 32'h0); end
    checks++; if (bus.data_sram_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.data_sram_err); end
    checks++; if (rd_cnt !== 32'h0) begin errors++; $display("FAIL reset_rd_cnt got=%h exp=0", rd_cnt); end
    checks++; if (wr_cnt !== 32'h0) begin errors++; $display("FAIL reset_wr_cnt got=%h exp=0", wr_cnt); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    req(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
    checks++; if (bus.data_sram_err !== 1'b0) begin errors++; $display("FAIL wr_err got=%b exp=0", bus.data_sram_err); end
    req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    checks++; if (bus.data_sram_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd_data got=%h exp=%h", bus.data_sram_rdata, 32'hDEAD_BEEF); end
    checks++; if (wr_cnt !== 32'd1) begin errors++; $display("FAIL wr_rd_wr_cnt got=%0d exp=1", wr_cnt); end
    checks++; if (rd_cnt !== 32'd1) begin errors++; $display("FAIL wr_rd_rd_cnt got=%0d exp=1", rd_cnt); end
  endtask

  task automatic test_byte_lanes();
    req(1'b1, 4'b0101, 32'h0000_0010, 32'h1122_3344);
    checks++; if (bus.data_sram_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_first got=%h exp=%h", bus.data_sram_rdata, 32'hDEAD_BEEF); end
    req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    checks++; if (bus.data_sram_rdata !== 32'hDE22_BE44) begin errors++; $display("FAIL byte_lanes got=%h exp=%h", bus.data_sram_rdata, 32'hDE22_BE44); end
    checks++; if (wr_cnt !== 32'd2 || rd_cnt !== 32'd2) begin errors++; $display("FAIL lanes_cnt got wr=%0d rd=%0d exp wr=2 rd=2", wr_cnt, rd_cnt); end
  endtask

  task automatic test_out_of_range();
    req(1'b1, 4'h0, 32'h0000_4000, 32'h0);
    checks++; if (bus.data_sram_err !== 1'b1) begin errors++; $display("FAIL oor_err got=%b exp=1", bus.data_sram_err); end
    checks++; if (bus.data_sram_rdata !== 32'h0) begin errors++; $display("FAIL oor_rdata got=%h exp=0", bus.data_sram_rdata); end
    checks++; if (wr_cnt !== 32'd2 || rd_cnt !== 32'd2) begin errors++; $display("FAIL oor_cnt got wr=%0d rd=%0d exp wr=2 rd=2", wr_cnt, rd_cnt); end
    @(negedge clk);
    checks++; if (bus.data_sram_err !== 1'b0) begin errors++; $display("FAIL oor_pulse got=%b exp=0", bus.data_sram_err); end
    checks++; if (bus.data_sram_rdata !== 32'h0) begin errors++; $display("FAIL oor_hold got=%h exp=0", bus.data_sram_rdata); end
    // Aliases to word 0x10 if the upper bits were ignored.
    req(1'b1, 4'hF, 32'h0000_4010, 32'hFFFF_FFFF);
    checks++; if (bus.data_sram_err !== 1'b1) begin errors++; $display("FAIL oor_wr_err got=%b exp=1", bus.data_sram_err); end
    checks++; if (wr_cnt !== 32'd2) begin errors++; $display("FAIL oor_wr_cnt got=%0d exp=2", wr_cnt); end
    req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    checks++; if (bus.data_sram_rdata !== 32'hDE22_BE44) begin errors++; $display("FAIL oor_no_write got=%h exp=%h", bus.data_sram_rdata, 32'hDE22_BE44); end
    checks++; if (rd_cnt !== 32'd3) begin errors++; $display("FAIL oor_rd_cnt got=%0d exp=3", rd_cnt); end
  endtask

  task automatic test_hold_misalign();
    req(1'b1, 4'h0, 32'h0000_0013, 32'h0);
    checks++; if (bus.data_sram_rdata !== 32'hDE22_BE44) begin errors++; $display("FAIL misalign got=%h exp=%h", bus.data_sram_rdata, 32'hDE22_BE44); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.data_sram_rdata !== 32'hDE22_BE44 || bus.data_sram_err !== 1'b0) begin
        errors++; $display("FAIL hold_%0d got rdata=%h err=%b exp rdata=%h err=0", i, bus.data_sram_rdata, bus.data_sram_err, 32'hDE22_BE44);
      end
    end
    checks++; if (rd_cnt !== 32'd4) begin errors++; $display("FAIL hold_rd_cnt got=%0d exp=4", rd_cnt); end
  endtask

  task automatic test_back_to_back();
    req(1'b1, 4'hF, 32'h0000_0020, 32'hA5A5_5A5A);
    req(1'b1, 4'h0, 32'h0000_0020, 32'h0);
    checks++; if (bus.data_sram_rdata !== 32'hA5A5_5A5A) begin errors++; $display("FAIL b2b_wr_rd got=%h exp=%h", bus.data_sram_rdata, 32'hA5A5_5A5A); end
    req(1'b1, 4'hF, 32'h0000_0024, 32'h0102_0304);
    req(1'b1, 4'h0, 32'h0000_0020, 32'h0);
    checks++; if (bus.data_sram_rdata !== 32'hA5A5_5A5A) begin errors++; $display("FAIL b2b_rd0 got=%h exp=%h", bus.data_sram_rdata, 32'hA5A5_5A5A); end
    req(1'b1, 4'h0, 32'h0000_0024, 32'h0);
    checks++; if (bus.data_sram_rdata !== 32'h0102_0304) begin errors++; $display("FAIL b2b_rd1 got=%h exp=%h", bus.data_sram_rdata, 32'h0102_0304); end
    req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    checks++; if (bus.data_sram_rdata !== 32'hDE22_BE44) begin errors++; $display("FAIL b2b_rd2 got=%h exp=%h", bus.data_sram_rdata, 32'hDE22_BE44); end
    checks++; if (rd_cnt !== 32'd8 || wr_cnt !== 32'd4) begin errors++; $display("FAIL b2b_cnt got rd=%0d wr=%0d exp rd=8 wr=4", rd_cnt, wr_cnt); end
  endtask

  task automatic test_saturation();
    force dut.wr_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.wr_cnt_q;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      req(1'b1, 4'hF, 32'h0000_0030, 32'h0000_0000 + i);
      checks++; if (wr_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_%0d got=%h exp=%h", i, wr_cnt, 32'hFFFF_FFFF); end
    end
    checks++; if (rd_cnt !== 32'd8) begin errors++; $display("FAIL sat_rd_cnt got=%0d exp=8", rd_cnt); end
  endtask

  task automatic test_async_reset();
    req(1'b1, 4'hF, 32'h0000_0040, 32'hCAFE_F00D);
    req(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    checks++; if (bus.data_sram_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL ar_pre got=%h exp=%h", bus.data_sram_rdata, 32'hCAFE_F00D); end
    bus.data_sram_en = 1'b1; bus.data_sram_we = 4'h0; bus.data_sram_addr = 32'h0000_0010;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.data_sram_rdata !== 32'h0 || bus.data_sram_err !== 1'b0) begin
      errors++; $display("FAIL ar_immediate got rdata=%h err=%b exp rdata=0 err=0", bus.data_sram_rdata, bus.data_sram_err);
    end
    checks++; if (rd_cnt !== 32'h0 || wr_cnt !== 32'h0) begin errors++; $display("FAIL ar_cnt got rd=%h wr=%h exp 0", rd_cnt, wr_cnt); end
    @(negedge clk);
    req(1'b1, 4'hF, 32'h0000_0040, 32'h0000_0000);
    checks++; if (bus.data_sram_rdata !== 32'h0 || wr_cnt !== 32'h0) begin
      errors++; $display("FAIL ar_in_reset got rdata=%h wr=%0d exp rdata=0 wr=0", bus.data_sram_rdata, wr_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
    req(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    checks++; if (bus.data_sram_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL ar_dropped_write got=%h exp=%h", bus.data_sram_rdata, 32'hCAFE_F00D); end
    checks++; if (rd_cnt !== 32'd1 || wr_cnt !== 32'd0) begin errors++; $display("FAIL ar_post_cnt got rd=%0d wr=%0d exp rd=1 wr=0", rd_cnt, wr_cnt); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_hold_misalign();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
